mipd_delay_meter: RTL and testbench



---
 rtl/mipd_delay_meter.sv | 120 ++++++++++++
 tb/tb_mipd_delay_meter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mipd_delay_meter.sv
// rtl/mipd_delay_meter.sv - measures stimulus-to-response propagation delay in clock cycles
module mipd_delay_meter #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             clr_stats,
    input  logic             stim_in,
    input  logic             resp_in,
    output logic             busy,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_delay,
    output logic             meas_rise,
    output logic             meas_timeout,
    output logic [CNT_W-1:0] rise_max,
    output logic [CNT_W-1:0] fall_max
);

    typedef enum logic [1:0] {IDLE, WAIT_STIM, COUNT, REPORT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

    state_t                 state;
    logic [SYNC_STAGES-1:0] stim_sync;
    logic [SYNC_STAGES-1:0] resp_sync;
    logic                   s_stim;
    logic                   s_resp;
    logic                   resp_dly;
    logic                   stim_ref;
    logic                   resp_ref;
    logic [CNT_W-1:0]       cnt;

    assign s_stim = stim_sync[SYNC_STAGES-1];
    assign s_resp = resp_sync[SYNC_STAGES-1];

    // resp_dly lags s_resp by one cycle so that the COUNT state, entered one
    // cycle after the stimulus edge is seen, still measures delay from that edge;
    // it also gives resp_ref the pre-edge level when both edges coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_sync <= '0;
            resp_sync <= '0;
            resp_dly  <= 1'b0;
        end else begin
            stim_sync <= {stim_sync[SYNC_STAGES-2:0], stim_in};
            resp_sync <= {resp_sync[SYNC_STAGES-2:0], resp_in};
            resp_dly  <= s_resp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            meas_valid   <= 1'b0;
            meas_delay   <= '0;
            meas_rise    <= 1'b0;
            meas_timeout <= 1'b0;
            rise_max     <= '0;
            fall_max     <= '0;
            stim_ref     <= 1'b0;
            resp_ref     <= 1'b0;
            cnt          <= '0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE, REPORT: begin
                    if (arm) begin
                        state    <= WAIT_STIM;
                        busy     <= 1'b1;
                        stim_ref <= s_stim;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_STIM: begin
                    if (s_stim != stim_ref) begin
                        state    <= COUNT;
                        resp_ref <= resp_dly;
                        cnt      <= '0;
                    end
                end
                COUNT: begin
                    if (resp_dly != resp_ref) begin
                        state        <= REPORT;
                        busy         <= 1'b0;
                        meas_valid   <= 1'b1;
                        meas_delay   <= cnt;
                        meas_rise    <= resp_dly;
                        meas_timeout <= 1'b0;
                        if (resp_dly && cnt > rise_max)
                            rise_max <= cnt;
                        if (!resp_dly && cnt > fall_max)
                            fall_max <= cnt;
                    end else if (cnt == CNT_LAST) begin
                        state        <= REPORT;
                        busy         <= 1'b0;
                        meas_valid   <= 1'b1;
                        meas_delay   <= TIMEOUT_VAL;
                        meas_rise    <= resp_dly;
                        meas_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a clear overrides a coincident statistics update.
            if (clr_stats) begin
                rise_max <= '0;
                fall_max <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mipd_delay_meter.sv
// tb/tb_mipd_delay_meter.sv - scoreboard bench for mipd_delay_meter
module tb_mipd_delay_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 24;
    localparam int SS    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             arm = 1'b0;
    logic             clr_stats = 1'b0;
    logic             stim_in = 1'b0;
    logic             resp_in = 1'b0;
    logic             busy;
    logic             meas_valid;
    logic [CNT_W-1:0] meas_delay;
    logic             meas_rise;
    logic             meas_timeout;
    logic [CNT_W-1:0] rise_max;
    logic [CNT_W-1:0] fall_max;

    mipd_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .clr_stats(clr_stats),
        .stim_in(stim_in), .resp_in(resp_in), .busy(busy),
        .meas_valid(meas_valid), .meas_delay(meas_delay), .meas_rise(meas_rise),
        .meas_timeout(meas_timeout), .rise_max(rise_max), .fall_max(fall_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int delay;
        bit rise;
        bit to;
        int rmax;
        int fmax;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   vcount = 0;
    int   exp_rmax = 0;
    int   exp_fmax = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && meas_valid) begin
            vcount++;
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("meas_delay", int'(meas_delay), e.delay);
                check("meas_timeout", int'(meas_timeout), int'(e.to));
                if (!e.to)
                    check("meas_rise", int'(meas_rise), int'(e.rise));
                check("rise_max", int'(rise_max), e.rmax);
                check("fall_max", int'(fall_max), e.fmax);
                check("busy_at_valid", int'(busy), 0);
            end
        end
    end

    // One armed measurement: response edge d cycles after the stimulus edge.
    task automatic run(input int d, input bit rise, input bit to, input bit clr, input bit extra);
        exp_t e;
        int   start;
        if (!to && resp_in != !rise) begin
            resp_in = !rise;
            repeat (6) @(negedge clk);
        end
        clr_stats = clr;
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        check("busy_after_arm", int'(busy), 1);
        repeat (2) @(negedge clk);
        e.delay = to ? TO : d;
        e.rise  = rise;
        e.to    = to;
        if (clr) begin
            exp_rmax = 0;
            exp_fmax = 0;
        end else if (!to) begin
            if (rise && d > exp_rmax) exp_rmax = d;
            if (!rise && d > exp_fmax) exp_fmax = d;
        end
        e.rmax = exp_rmax;
        e.fmax = exp_fmax;
        sb.push_back(e);
        start = vcount;
        stim_in = !stim_in;
        if (!to && d == 0) resp_in = rise;
        if (!to && d > 0) begin
            for (int i = 1; i <= d; i++) begin
                @(negedge clk);
                if (extra && i == 5) begin arm = 1'b1; stim_in = !stim_in; end
                if (extra && i == 6) begin arm = 1'b0; stim_in = !stim_in; end
                if (i == d) resp_in = rise;
            end
        end
        for (int i = 0; i < 200 && vcount == start; i++) @(negedge clk);
        @(negedge clk);
        clr_stats = 1'b0;
        repeat (30) @(negedge clk);
        check("report_count", vcount - start, 1);
    endtask

    initial begin
        int vsave;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(meas_valid), 0);
        check("rst_delay", int'(meas_delay), 0);
        check("rst_rise_max", int'(rise_max), 0);
        check("rst_fall_max", int'(fall_max), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run(7, 1'b1, 1'b0, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0, 1'b0, 1'b0);
        run(12, 1'b0, 1'b0, 1'b0, 1'b0);
        run(9, 1'b0, 1'b0, 1'b0, 1'b0);
        run(0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(20, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clr_rise_max", int'(rise_max), 0);
        check("clr_fall_max", int'(fall_max), 0);
        run(0, 1'b1, 1'b0, 1'b0, 1'b0);
        run(10, 1'b0, 1'b0, 1'b0, 1'b1);

        vsave = vcount;
        if (resp_in != 1'b0) begin
            resp_in = 1'b0;
            repeat (6) @(negedge clk);
        end
        @(negedge clk) arm = 1'b1;
        @(negedge clk) arm = 1'b0;
        repeat (2) @(negedge clk);
        stim_in = !stim_in;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(meas_valid), 0);
        check("mid_rst_fields", int'({meas_delay, meas_rise, meas_timeout}), 0);
        check("mid_rst_maxima", int'({rise_max, fall_max}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_rst_no_valid", vcount - vsave, 0);
        exp_rmax = 0;
        exp_fmax = 0;
        run(4, 1'b1, 1'b0, 1'b0, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
